// File: rtl/fetch_buffer_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
package fetch_buffer_pkg;

  localparam logic [31:0] RESET_PC = 32'h1c00_0000;
  localparam int unsigned PC_STEP  = 4;

  // Entry view at the default 32-bit address/instruction widths.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer_ram.sv
// Entry storage for fetch_buffer: allocate writes pc, fill writes inst, head is read.
module fetch_buffer_ram #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned INST_WIDTH = 32,
  localparam int unsigned IDX_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  alloc_en,
  input  logic [IDX_W-1:0]      alloc_idx,
  input  logic [ADDR_WIDTH-1:0] alloc_pc,
  input  logic                  fill_en,
  input  logic [IDX_W-1:0]      fill_idx,
  input  logic [INST_WIDTH-1:0] fill_inst,
  input  logic                  deq_en,
  input  logic [IDX_W-1:0]      head_idx,
  output logic [ADDR_WIDTH-1:0] head_pc,
  output logic [INST_WIDTH-1:0] head_inst,
  output logic                  head_filled
);
  import fetch_buffer_pkg::*;

  logic [ADDR_WIDTH-1:0] pc_q   [DEPTH];
  logic [INST_WIDTH-1:0] inst_q [DEPTH];
  logic [DEPTH-1:0]      filled_q;

  // Allocate, fill and dequeue never target the same slot in one cycle:
  // fill only hits allocated-unfilled slots, dequeue only the filled head.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        inst_q[i] <= '0;
      end
      filled_q <= '0;
    end else if (clear) begin
      filled_q <= '0;
    end else begin
      if (alloc_en) begin
        pc_q[alloc_idx]     <= alloc_pc;
        filled_q[alloc_idx] <= 1'b0;
      end
      if (fill_en) begin
        inst_q[fill_idx]   <= fill_inst;
        filled_q[fill_idx] <= 1'b1;
      end
      if (deq_en) begin
        filled_q[head_idx] <= 1'b0;
      end
    end
  end

  always_comb begin
    head_pc     = pc_q[head_idx];
    head_inst   = inst_q[head_idx];
    head_filled = filled_q[head_idx];
  end

endmodule

// File: rtl/fetch_buffer.sv
// Instruction prefetch buffer: credit-limited in-order fetch, PC/instruction
// pairing, and flush redirect that drops responses from the squashed path.
module fetch_buffer #(
  parameter int unsigned           DEPTH      = 4,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           INST_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(fetch_buffer_pkg::RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] flush_pc,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  resp_valid,
  input  logic [INST_WIDTH-1:0] resp_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [INST_WIDTH-1:0] out_inst
);
  import fetch_buffer_pkg::*;

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] DEPTH_PTR = PTR_W'(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0]      alloc_ptr, fill_ptr, head_ptr;
  logic [PTR_W-1:0]      discard_cnt;
  logic [ADDR_WIDTH-1:0] fetch_pc;

  logic [PTR_W-1:0]      used, in_flight, pending;
  logic [CNT_W-1:0]      credit_used;
  logic                  req_fire, resp_drop, resp_fill, deq_fire;
  logic [ADDR_WIDTH-1:0] head_pc;
  logic [INST_WIDTH-1:0] head_inst;
  logic                  head_filled;

  // Stale responses still owed by memory consume credit alongside live entries,
  // so discard_cnt + used never exceeds DEPTH and fits in PTR_W bits.
  always_comb begin
    used        = alloc_ptr - head_ptr;
    in_flight   = alloc_ptr - fill_ptr;
    pending     = in_flight + discard_cnt;
    credit_used = {1'b0, discard_cnt} + {1'b0, used};

    req_valid = rst & ~flush & (used < DEPTH_PTR) & (credit_used < DEPTH_CNT);
    req_addr  = fetch_pc;
    req_fire  = req_valid & req_ready;

    resp_drop = resp_valid & (discard_cnt != '0);
    resp_fill = resp_valid & (discard_cnt == '0) & ~flush;

    out_valid = head_filled & (used != '0);
    out_pc    = out_valid ? head_pc   : '0;
    out_inst  = out_valid ? head_inst : '0;
    deq_fire  = out_valid & out_ready & ~flush;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      alloc_ptr   <= '0;
      fill_ptr    <= '0;
      head_ptr    <= '0;
      discard_cnt <= '0;
    end else if (flush) begin
      // Everything owed by memory becomes stale; the response landing now is dropped.
      discard_cnt <= pending - PTR_W'(resp_valid);
      alloc_ptr   <= '0;
      fill_ptr    <= '0;
      head_ptr    <= '0;
      fetch_pc    <= flush_pc;
    end else begin
      if (req_fire) begin
        alloc_ptr <= alloc_ptr + PTR_W'(1);
        fetch_pc  <= fetch_pc + ADDR_WIDTH'(PC_STEP);
      end
      if (resp_drop) begin
        discard_cnt <= discard_cnt - PTR_W'(1);
      end else if (resp_valid) begin
        fill_ptr <= fill_ptr + PTR_W'(1);
      end
      if (deq_fire) begin
        head_ptr <= head_ptr + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!(resp_valid && pending == '0));
    end
  end

  fetch_buffer_ram #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .INST_WIDTH (INST_WIDTH)
  ) u_ram (
    .clk         (clk),
    .rst         (rst),
    .clear       (flush),
    .alloc_en    (req_fire),
    .alloc_idx   (alloc_ptr[IDX_W-1:0]),
    .alloc_pc    (fetch_pc),
    .fill_en     (resp_fill),
    .fill_idx    (fill_ptr[IDX_W-1:0]),
    .fill_inst   (resp_data),
    .deq_en      (deq_fire),
    .head_idx    (head_ptr[IDX_W-1:0]),
    .head_pc     (head_pc),
    .head_inst   (head_inst),
    .head_filled (head_filled)
  );

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: queue-based memory and expected-output model, scenario tasks.
module tb_fetch_buffer;
  import fetch_buffer_pkg::*;

  localparam int unsigned DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h1c00_0000;

  logic        clk        = 1'b0;
  logic        rst        = 1'b0;
  logic        flush      = 1'b0;
  logic [31:0] flush_pc   = '0;
  logic        req_valid;
  logic        req_ready  = 1'b0;
  logic [31:0] req_addr;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_data  = '0;
  logic        out_valid;
  logic        out_ready  = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  fetch_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .INST_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .flush_pc(flush_pc),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9e37_79b1) ^ 32'h5a5a_0f0f;
  endfunction

  // Memory model: requests owed with their due cycle and the flush epoch they belong to.
  typedef struct {
    logic [31:0] addr;
    int unsigned due;
    int unsigned epoch;
  } mreq_t;

  mreq_t        mq[$];
  fetch_entry_t eq[$];
  int unsigned  cyc = 0;
  int unsigned  mem_lat = 1;
  int unsigned  epoch = 0;
  logic [31:0]  model_pc = RST_PC;
  int unsigned  err_req = 0, err_addr = 0, err_out = 0;
  int unsigned  n_deq = 0, max_total = 0;
  string        note_req = "", note_addr = "", note_out = "";

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    int unsigned  tot;
    bit           exp_rv, exp_ov;
    logic [31:0]  e_pc, e_inst;
    mreq_t        r;
    resp_valid = 1'b0;
    resp_data  = '0;
    if (mq.size() != 0 && mq[0].due <= cyc) begin
      resp_valid = 1'b1;
      resp_data  = mem_data(mq[0].addr);
    end
    #2;
    tot = mq.size() + eq.size();
    if (tot > max_total) max_total = tot;
    exp_rv = rst && !flush && (tot < DEPTH);
    if (req_valid !== exp_rv) begin
      err_req++;
      note_req = $sformatf("cyc %0d req_valid=%b want %b", cyc, req_valid, exp_rv);
    end
    if (exp_rv && req_addr !== model_pc) begin
      err_addr++;
      note_addr = $sformatf("cyc %0d req_addr=%h want %h", cyc, req_addr, model_pc);
    end
    exp_ov = (eq.size() != 0);
    e_pc   = exp_ov ? eq[0].pc   : 32'h0;
    e_inst = exp_ov ? eq[0].inst : 32'h0;
    if (out_valid !== exp_ov || out_pc !== e_pc || out_inst !== e_inst) begin
      err_out++;
      note_out = $sformatf("cyc %0d out v/pc/inst=%b/%h/%h want %b/%h/%h",
                           cyc, out_valid, out_pc, out_inst, exp_ov, e_pc, e_inst);
    end
    if (!rst) begin
      mq.delete();
      eq.delete();
      model_pc = RST_PC;
    end else if (flush) begin
      if (resp_valid) r = mq.pop_front();
      eq.delete();
      model_pc = flush_pc;
      epoch++;
    end else begin
      if (exp_ov && out_ready) begin
        void'(eq.pop_front());
        n_deq++;
      end
      if (resp_valid) begin
        r = mq.pop_front();
        if (r.epoch == epoch) eq.push_back('{pc: r.addr, inst: mem_data(r.addr), filled: 1'b1});
      end
      if (req_valid && req_ready) begin
        mq.push_back('{addr: model_pc, due: cyc + mem_lat, epoch: epoch});
        model_pc = model_pc + 32'd4;
      end
    end
  end

  task automatic reset_to(input int unsigned lat, input logic rr, input logic orr);
    @(negedge clk); rst = 1'b0; flush = 1'b0; req_ready = rr; out_ready = orr; mem_lat = lat; #3;
    @(negedge clk); rst = 1'b1; #3;
  endtask

  task automatic test_reset;
    int unsigned k;
    @(negedge clk); rst = 1'b0; flush = 1'b0; req_ready = 1'b1; out_ready = 1'b1; mem_lat = 1; #3;
    repeat (2) begin @(negedge clk); #3; end
    n_checks++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b want 0", req_valid); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL reset_out_pc: got %h want 0", out_pc); end
    n_checks++; if (out_inst !== 32'h0) begin n_fail++; $display("FAIL reset_out_inst: got %h want 0", out_inst); end
    @(negedge clk); rst = 1'b1; #3;
    n_checks++;
    if (req_valid !== 1'b1 || req_addr !== RST_PC) begin
      n_fail++; $display("FAIL first_request: valid=%b addr=%h want 1 %h", req_valid, req_addr, RST_PC);
    end
    k = 0;
    while (out_valid !== 1'b1 && k < 10) begin @(negedge clk); #3; k++; end
    n_checks++; if (k != 2) begin n_fail++; $display("FAIL first_out_latency: got %0d cycles want 2", k); end
    n_checks++;
    if (out_pc !== RST_PC || out_inst !== mem_data(RST_PC)) begin
      n_fail++; $display("FAIL first_out: pc=%h inst=%h want %h %h", out_pc, out_inst, RST_PC, mem_data(RST_PC));
    end
  endtask

  task automatic test_stream;
    logic [31:0] exp_pc;
    int unsigned e0;
    e0 = err_req + err_addr + err_out;
    exp_pc = RST_PC + 32'd4;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #3;
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== exp_pc || out_inst !== mem_data(exp_pc)) begin
        n_fail++;
        $display("FAIL stream[%0d]: v=%b pc=%h inst=%h want 1 %h %h", i, out_valid, out_pc, out_inst, exp_pc, mem_data(exp_pc));
      end
      exp_pc = exp_pc + 32'd4;
    end
    n_checks++;
    if (err_req + err_addr + err_out != e0) begin
      n_fail++; $display("FAIL stream_model: errors %0d want %0d (%s %s %s)", err_req + err_addr + err_out, e0, note_req, note_addr, note_out);
    end
  endtask

  task automatic test_stall;
    int unsigned cnt, nd;
    logic [31:0] first_addr;
    bit seen;
    @(negedge clk); rst = 1'b0; flush = 1'b0; req_ready = 1'b1; out_ready = 1'b0; mem_lat = 1; #3;
    @(negedge clk); rst = 1'b1; #3;
    cnt = (req_valid === 1'b1) ? 1 : 0;
    repeat (9) begin @(negedge clk); #3; if (req_valid === 1'b1) cnt++; end
    n_checks++; if (cnt != 4) begin n_fail++; $display("FAIL stall_requests: got %0d want 4", cnt); end
    n_checks++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL stall_req_valid: got %b want 0", req_valid); end
    n_checks++; if (out_valid !== 1'b1 || out_pc !== RST_PC) begin n_fail++; $display("FAIL stall_head: v=%b pc=%h want 1 %h", out_valid, out_pc, RST_PC); end
    @(negedge clk); out_ready = 1'b1; #3;
    nd = 0; seen = 0; first_addr = '0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid === 1'b1) begin
        if (nd < 4) begin
          n_checks++;
          if (out_pc !== RST_PC + 32'(4 * nd)) begin
            n_fail++; $display("FAIL stall_drain[%0d]: pc=%h want %h", nd, out_pc, RST_PC + 32'(4 * nd));
          end
        end
        nd++;
      end
      if (req_valid === 1'b1 && !seen) begin seen = 1; first_addr = req_addr; end
      @(negedge clk); #3;
    end
    n_checks++; if (nd < 4) begin n_fail++; $display("FAIL stall_drain_count: got %0d want >=4", nd); end
    n_checks++; if (first_addr !== RST_PC + 32'h10) begin n_fail++; $display("FAIL stall_resume_addr: got %h want %h", first_addr, RST_PC + 32'h10); end
  endtask

  task automatic test_flush_discard;
    int unsigned k, e0;
    e0 = err_out;
    @(negedge clk); rst = 1'b0; flush = 1'b0; req_ready = 1'b0; out_ready = 1'b1; mem_lat = 3; #3;
    @(negedge clk); rst = 1'b1; req_ready = 1'b1; #3;
    @(negedge clk); #3;
    @(negedge clk); req_ready = 1'b0; flush = 1'b1; flush_pc = 32'h1c00_0100; #3;
    n_checks++; if (req_valid !== 1'b0) begin n_fail++; $display("FAIL flush_blocks_req: got %b want 0", req_valid); end
    @(negedge clk); flush = 1'b0; req_ready = 1'b1; #3;
    k = 0;
    while (out_valid !== 1'b1 && k < 30) begin @(negedge clk); #3; k++; end
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h1c00_0100 || out_inst !== mem_data(32'h1c00_0100)) begin
      n_fail++; $display("FAIL flush_first_out: v=%b pc=%h inst=%h want 1 1c000100 %h", out_valid, out_pc, out_inst, mem_data(32'h1c00_0100));
    end
    repeat (10) begin @(negedge clk); #3; end
    n_checks++; if (err_out != e0) begin n_fail++; $display("FAIL flush_discard_stream: errors %0d want %0d (%s)", err_out, e0, note_out); end
  endtask

  task automatic test_flush_resp;
    int unsigned k, e0;
    e0 = err_out + err_req;
    @(negedge clk); rst = 1'b0; flush = 1'b0; req_ready = 1'b0; out_ready = 1'b1; mem_lat = 2; #3;
    @(negedge clk); rst = 1'b1; req_ready = 1'b1; #3;
    @(negedge clk); #3;
    @(negedge clk); req_ready = 1'b0; flush = 1'b1; flush_pc = 32'h1c00_0200; #3;
    @(negedge clk); flush = 1'b0; req_ready = 1'b1; #3;
    k = 0;
    while (out_valid !== 1'b1 && k < 30) begin @(negedge clk); #3; k++; end
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h1c00_0200) begin
      n_fail++; $display("FAIL flush_resp_first_out: v=%b pc=%h want 1 1c000200", out_valid, out_pc);
    end
    repeat (10) begin @(negedge clk); #3; end
    n_checks++; if (err_out + err_req != e0) begin n_fail++; $display("FAIL flush_resp_model: errors %0d want %0d (%s %s)", err_out + err_req, e0, note_out, note_req); end
  endtask

  task automatic test_back_to_back;
    int unsigned k, e0;
    e0 = err_req + err_addr + err_out;
    reset_to(3, 1'b1, 1'b0);
    max_total = 0;
    repeat (2) begin @(negedge clk); #3; end
    @(negedge clk); flush = 1'b1; flush_pc = 32'h0000_0200; #3;
    @(negedge clk); flush_pc = 32'h0000_0300; #3;
    @(negedge clk); flush = 1'b0; out_ready = 1'b1; #3;
    k = 0;
    while (out_valid !== 1'b1 && k < 30) begin @(negedge clk); #3; k++; end
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0000_0300 || out_inst !== mem_data(32'h0000_0300)) begin
      n_fail++; $display("FAIL b2b_first_out: v=%b pc=%h inst=%h want 1 00000300 %h", out_valid, out_pc, out_inst, mem_data(32'h0000_0300));
    end
    for (int i = 0; i < 30; i++) begin @(negedge clk); out_ready = ($urandom_range(0, 2) != 0); #3; end
    n_checks++; if (max_total > DEPTH) begin n_fail++; $display("FAIL b2b_credit: peak %0d want <= %0d", max_total, DEPTH); end
    n_checks++; if (err_req + err_addr + err_out != e0) begin n_fail++; $display("FAIL b2b_model: errors %0d want %0d (%s %s %s)", err_req + err_addr + err_out, e0, note_req, note_addr, note_out); end
  endtask

  task automatic test_reset_inflight;
    int unsigned e0;
    reset_to(3, 1'b1, 1'b1);
    repeat (5) begin @(negedge clk); #3; end
    @(negedge clk); rst = 1'b0; #3;
    @(negedge clk); rst = 1'b1; #3;
    n_checks++; if (out_valid !== 1'b0 || out_pc !== 32'h0) begin n_fail++; $display("FAIL rst_inflight_out: v=%b pc=%h want 0 0", out_valid, out_pc); end
    n_checks++; if (req_valid !== 1'b1 || req_addr !== RST_PC) begin n_fail++; $display("FAIL rst_inflight_restart: v=%b addr=%h want 1 %h", req_valid, req_addr, RST_PC); end
    e0 = err_req + err_addr + err_out;
    repeat (20) begin @(negedge clk); #3; end
    n_checks++; if (err_req + err_addr + err_out != e0) begin n_fail++; $display("FAIL rst_inflight_model: errors %0d want %0d (%s %s %s)", err_req + err_addr + err_out, e0, note_req, note_addr, note_out); end
  endtask

  task automatic test_random;
    int unsigned k, d0;
    int unsigned er0, ea0, eo0;
    er0 = err_req; ea0 = err_addr; eo0 = err_out; d0 = n_deq;
    max_total = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (i % 50 == 0) mem_lat = $urandom_range(1, 4);
      req_ready = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 4) < 3);
      flush     = ($urandom_range(0, 19) == 0);
      flush_pc  = 32'h1c00_0000 + ($urandom_range(0, 1023) << 2);
      #3;
    end
    @(negedge clk); flush = 1'b0; req_ready = 1'b0; out_ready = 1'b1; #3;
    k = 0;
    while ((mq.size() != 0 || eq.size() != 0) && k < 60) begin @(negedge clk); #3; k++; end
    n_checks++; if (k >= 60) begin n_fail++; $display("FAIL random_drain: %0d owed %0d held after %0d cycles", mq.size(), eq.size(), k); end
    n_checks++; if (err_req != er0) begin n_fail++; $display("FAIL random_req_valid: errors %0d want %0d (%s)", err_req, er0, note_req); end
    n_checks++; if (err_addr != ea0) begin n_fail++; $display("FAIL random_req_addr: errors %0d want %0d (%s)", err_addr, ea0, note_addr); end
    n_checks++; if (err_out != eo0) begin n_fail++; $display("FAIL random_output: errors %0d want %0d (%s)", err_out, eo0, note_out); end
    n_checks++; if (max_total > DEPTH) begin n_fail++; $display("FAIL random_credit: peak %0d want <= %0d", max_total, DEPTH); end
    n_checks++; if (n_deq - d0 < 50) begin n_fail++; $display("FAIL random_progress: dequeues %0d want >= 50", n_deq - d0); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush_discard();
    test_flush_resp();
    test_back_to_back();
    test_reset_inflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
